// File: rtl/input_port_unit_if.sv
// Flit-side and allocator-side signals of one router input port.
// The master side is the upstream neighbour plus the switch allocator; the slave side is the port unit.
interface input_port_unit_if #(
  parameter int FLIT_SIZE = 8,
  parameter int OP_SIZE   = 3
);
  logic                 wr_en;
  logic [FLIT_SIZE-1:0] flit_in;
  logic                 rd_en;
  logic [FLIT_SIZE-1:0] in_buf;
  logic                 empty;
  logic                 full;
  logic [OP_SIZE-1:0]   op_port;
  logic                 ON_OFF_signal;
  logic                 protocol_err;

  modport master (
    output wr_en, flit_in, rd_en,
    input  in_buf, empty, full, op_port, ON_OFF_signal, protocol_err
  );

  modport slave (
    input  wr_en, flit_in, rd_en,
    output in_buf, empty, full, op_port, ON_OFF_signal, protocol_err
  );
endinterface

// File: rtl/input_port_unit.sv
// Wormhole router input port: flit FIFO, XY route compute, per-packet route hold
// and ON/OFF backpressure toward the upstream router.
module input_port_unit #(
  parameter int FLIT_SIZE = 8,
  parameter int OP_SIZE   = 3,
  parameter int BUF_DEPTH = 4,
  parameter int COORD_W   = 3,
  parameter int OFF_TH    = 3,
  parameter int ON_TH     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input_port_unit_if.slave   port
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [OP_SIZE-1:0] OP_N = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_E = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_S = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_W = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_L = OP_SIZE'(4);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [FLIT_SIZE-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_wr, do_rd;
  logic                 empty, full;
  logic [FLIT_SIZE-1:0] head_flit;
  logic                 is_head, is_tail;
  logic [OP_SIZE-1:0]   route_cur, route_q;
  state_t               state_q, state_d;
  logic                 route_ld, seq_err;
  logic                 on_off_q, err_q;

  // XY dimension-order routing: resolve X first, then Y.
  function automatic logic [OP_SIZE-1:0] xy_route(
    input logic [FLIT_SIZE-1:0] f,
    input logic [COORD_W-1:0]   cx,
    input logic [COORD_W-1:0]   cy
  );
    logic [COORD_W-1:0] dx, dy;
    dx = f[2*COORD_W-1 -: COORD_W];
    dy = f[COORD_W-1:0];
    if (dx > cx)      return OP_E;
    else if (dx < cx) return OP_W;
    else if (dy < cy) return OP_N;
    else if (dy > cy) return OP_S;
    else              return OP_L;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(BUF_DEPTH));
  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign do_rd = port.rd_en && !empty;
  assign do_wr = port.wr_en && (!full || port.rd_en);

  assign head_flit = mem[rd_ptr];
  assign is_head   = head_flit[FLIT_SIZE-1];
  assign is_tail   = head_flit[FLIT_SIZE-2];
  assign route_cur = xy_route(head_flit, cur_x, cur_y);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= port.flit_in;
  end

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + CNT_W'(1);
    else if (!do_wr && do_rd) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Packet state register, route latch and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      route_q <= OP_L;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (route_ld) route_q <= route_cur;
      if (seq_err || (port.wr_en && full && !port.rd_en)) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    route_ld = 1'b0;
    seq_err  = 1'b0;
    if (do_rd) begin
      case (state_q)
        IDLE: begin
          if (!is_head) begin
            seq_err = 1'b1;
          end else if (!is_tail) begin
            state_d  = ACTIVE;
            route_ld = 1'b1;
          end
        end
        ACTIVE: begin
          if (is_head)      seq_err = 1'b1;
          else if (is_tail) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    port.op_port = OP_L;
    if (state_q == ACTIVE)         port.op_port = route_q;
    else if (!empty && is_head)    port.op_port = route_cur;
  end

  // Hysteresis on the post-update occupancy so upstream sees the change one cycle sooner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on_off_q <= 1'b1;
    end else if (count_d >= CNT_W'(OFF_TH)) begin
      on_off_q <= 1'b0;
    end else if (count_d <= CNT_W'(ON_TH)) begin
      on_off_q <= 1'b1;
    end
  end

  assign port.in_buf        = head_flit;
  assign port.empty         = empty;
  assign port.full          = full;
  assign port.ON_OFF_signal = on_off_q;
  assign port.protocol_err  = err_q;

endmodule

// File: tb/tb_input_port_unit.sv
// Directed self-checking bench for input_port_unit at router coordinate (1,1).
module tb_input_port_unit;
  logic       clk;
  logic       rst;
  logic [2:0] cur_x;
  logic [2:0] cur_y;
  int         n_checks;
  int         n_fail;

  input_port_unit_if #(.FLIT_SIZE(8), .OP_SIZE(3)) pif ();

  input_port_unit #(
    .FLIT_SIZE(8), .OP_SIZE(3), .BUF_DEPTH(4), .COORD_W(3), .OFF_TH(3), .ON_TH(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .port  (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pif.wr_en   = 1'b0;
    pif.rd_en   = 1'b0;
    pif.flit_in = 8'h00;
    rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pif.wr_en = 1'b0; pif.rd_en = 1'b0; pif.flit_in = 8'h00;
    tick(); tick();
    n_checks++; if (pif.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", pif.empty); end
    n_checks++; if (pif.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", pif.full); end
    n_checks++; if (pif.ON_OFF_signal !== 1'b1) begin n_fail++; $display("FAIL reset_onoff: got %b want 1", pif.ON_OFF_signal); end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", pif.protocol_err); end
    n_checks++; if (pif.op_port !== 3'd4) begin n_fail++; $display("FAIL reset_op: got %0d want 4", pif.op_port); end
    #2 rst = 1'b1;
    tick();
    // Load a body flit and a head flit, then pop the body flit while IDLE.
    pif.wr_en = 1'b1; pif.flit_in = 8'h15; tick();
    pif.flit_in = 8'h9A; tick();
    pif.wr_en = 1'b0; pif.rd_en = 1'b1; tick();
    pif.rd_en = 1'b0;
    n_checks++; if (pif.protocol_err !== 1'b1) begin n_fail++; $display("FAIL body_in_idle_err: got %b want 1", pif.protocol_err); end
    n_checks++; if (pif.empty !== 1'b0) begin n_fail++; $display("FAIL pre_reset_occupied: got empty=%b want 0", pif.empty); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (pif.empty !== 1'b1) begin n_fail++; $display("FAIL async_reset_empty: got %b want 1", pif.empty); end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_err: got %b want 0", pif.protocol_err); end
    n_checks++; if (pif.op_port !== 3'd4) begin n_fail++; $display("FAIL async_reset_op: got %0d want 4", pif.op_port); end
    n_checks++; if (pif.ON_OFF_signal !== 1'b1) begin n_fail++; $display("FAIL async_reset_onoff: got %b want 1", pif.ON_OFF_signal); end
    #1 rst = 1'b1;
    tick();
    n_checks++; if (pif.empty !== 1'b1) begin n_fail++; $display("FAIL flits_discarded: got empty=%b want 1", pif.empty); end
  endtask

  task automatic test_packet();
    logic [7:0] flits [3];
    int k;
    flits[0] = 8'b10_011_001; flits[1] = 8'h15; flits[2] = 8'h55;
    k = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      if (!pif.empty) begin
        n_checks++; if (pif.in_buf !== flits[k]) begin n_fail++; $display("FAIL pkt_flit%0d: got %h want %h", k, pif.in_buf, flits[k]); end
        n_checks++; if (pif.op_port !== 3'd1) begin n_fail++; $display("FAIL pkt_op%0d: got %0d want 1", k, pif.op_port); end
        pif.rd_en = 1'b1;
        k++;
      end else begin
        pif.rd_en = 1'b0;
      end
      pif.wr_en   = (c < 3);
      pif.flit_in = (c < 3) ? flits[c] : 8'h00;
      tick();
    end
    pif.wr_en = 1'b0; pif.rd_en = 1'b0;
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL pkt_timeout: got %0d flits want 3", k); end
    n_checks++; if (pif.empty !== 1'b1) begin n_fail++; $display("FAIL pkt_drained: got empty=%b want 1", pif.empty); end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL pkt_err: got %b want 0", pif.protocol_err); end
  endtask

  task automatic test_single_flit();
    logic [7:0] f   [4];
    logic [2:0] exp [4];
    f[0] = 8'b11_001_000; exp[0] = 3'd0;
    f[1] = 8'b11_001_001; exp[1] = 3'd4;
    f[2] = 8'b11_001_011; exp[2] = 3'd2;
    f[3] = 8'b11_000_001; exp[3] = 3'd3;
    // A stuck ACTIVE state after a head+tail would hold the previous route instead.
    for (int i = 0; i < 4; i++) begin
      pif.wr_en = 1'b1; pif.flit_in = f[i]; tick();
      pif.wr_en = 1'b0;
      n_checks++; if (pif.op_port !== exp[i]) begin n_fail++; $display("FAIL single_op%0d: got %0d want %0d", i, pif.op_port, exp[i]); end
      pif.rd_en = 1'b1; tick();
      pif.rd_en = 1'b0;
    end
    n_checks++; if (pif.empty !== 1'b1) begin n_fail++; $display("FAIL single_drained: got empty=%b want 1", pif.empty); end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", pif.protocol_err); end
  endtask

  task automatic test_fill_hysteresis();
    logic       exp_on   [4];
    logic       exp_full [4];
    logic [7:0] fl;
    exp_on[0] = 1'b1; exp_on[1] = 1'b1; exp_on[2] = 1'b0; exp_on[3] = 1'b0;
    exp_full[0] = 1'b0; exp_full[1] = 1'b0; exp_full[2] = 1'b0; exp_full[3] = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fl = 8'hC1 + 8'(i);
      pif.wr_en = 1'b1; pif.flit_in = fl; tick();
      n_checks++; if (pif.ON_OFF_signal !== exp_on[i]) begin n_fail++; $display("FAIL fill_onoff%0d: got %b want %b", i + 1, pif.ON_OFF_signal, exp_on[i]); end
      n_checks++; if (pif.full !== exp_full[i]) begin n_fail++; $display("FAIL fill_full%0d: got %b want %b", i + 1, pif.full, exp_full[i]); end
    end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL fill_err_before_drop: got %b want 0", pif.protocol_err); end
    pif.flit_in = 8'hC5; tick();
    pif.wr_en = 1'b0;
    n_checks++; if (pif.protocol_err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", pif.protocol_err); end
    n_checks++; if (pif.full !== 1'b1) begin n_fail++; $display("FAIL drop_full: got %b want 1", pif.full); end
    exp_on[0] = 1'b0; exp_on[1] = 1'b0; exp_on[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fl = 8'hC1 + 8'(i);
      n_checks++; if (pif.in_buf !== fl) begin n_fail++; $display("FAIL drain_flit%0d: got %h want %h", i, pif.in_buf, fl); end
      pif.rd_en = 1'b1; tick();
      n_checks++; if (pif.ON_OFF_signal !== exp_on[i]) begin n_fail++; $display("FAIL drain_onoff%0d: got %b want %b", 3 - i, pif.ON_OFF_signal, exp_on[i]); end
    end
    pif.rd_en = 1'b0;
    n_checks++; if (pif.in_buf !== 8'hC4) begin n_fail++; $display("FAIL drop_not_stored: got %h want c4", pif.in_buf); end
  endtask

  task automatic test_full_rw();
    logic [7:0] fl;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pif.wr_en = 1'b1; pif.flit_in = 8'hC1 + 8'(i); tick();
    end
    n_checks++; if (pif.full !== 1'b1) begin n_fail++; $display("FAIL rw_full_before: got %b want 1", pif.full); end
    n_checks++; if (pif.in_buf !== 8'hC1) begin n_fail++; $display("FAIL rw_oldest: got %h want c1", pif.in_buf); end
    pif.wr_en = 1'b1; pif.rd_en = 1'b1; pif.flit_in = 8'hC5; tick();
    pif.wr_en = 1'b0; pif.rd_en = 1'b0;
    n_checks++; if (pif.full !== 1'b1) begin n_fail++; $display("FAIL rw_full_after: got %b want 1", pif.full); end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL rw_err: got %b want 0", pif.protocol_err); end
    for (int i = 0; i < 4; i++) begin
      fl = 8'hC2 + 8'(i);
      n_checks++; if (pif.in_buf !== fl) begin n_fail++; $display("FAIL rw_wrap_flit%0d: got %h want %h", i, pif.in_buf, fl); end
      pif.rd_en = 1'b1; tick();
    end
    pif.rd_en = 1'b0;
    n_checks++; if (pif.empty !== 1'b1) begin n_fail++; $display("FAIL rw_drained: got empty=%b want 1", pif.empty); end
  endtask

  task automatic test_wormhole_hold();
    logic [7:0] f [3];
    f[0] = 8'b10_011_001; f[1] = 8'b00_000_001; f[2] = 8'b01_000_000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pif.wr_en = 1'b1; pif.flit_in = f[i]; tick();
    end
    pif.wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pif.op_port !== 3'd1) begin n_fail++; $display("FAIL hold_op%0d: got %0d want 1", i, pif.op_port); end
      pif.rd_en = 1'b1; tick();
    end
    pif.rd_en = 1'b0;
    n_checks++; if (pif.op_port !== 3'd4) begin n_fail++; $display("FAIL hold_release_op: got %0d want 4", pif.op_port); end
    n_checks++; if (pif.protocol_err !== 1'b0) begin n_fail++; $display("FAIL hold_err: got %b want 0", pif.protocol_err); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur_x = 3'd1;
    cur_y = 3'd1;
    test_reset();
    test_packet();
    test_single_flit();
    test_fill_hysteresis();
    test_full_rw();
    test_wormhole_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/input_port_unit.md
Name: input_port_unit

Overview:
- Per-input-port front end of the wormhole router; one instance per port (north, east, south, west, local).
- Buffers incoming flits in a FIFO and computes the XY route from the head flit.
- Holds that route from head to tail, and presents empty, head-of-queue flit and op_port to the switch allocator.
- Consumes the allocator's rd_en and drives ON/OFF backpressure to the upstream neighbour.

Parameters:
- FLIT_SIZE, 8, flit width in bits.
- OP_SIZE, 3, output-port code width.
- BUF_DEPTH, 4, FIFO depth in flits; power of 2, at least 2.
- COORD_W, 3, width of each X/Y coordinate field.
- OFF_TH, 3, occupancy at or above which ON_OFF_signal goes low.
- ON_TH, 1, occupancy at or below which ON_OFF_signal goes high; ON_TH < OFF_TH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cur_x  in  COORD_W  this router's X coordinate; static.
- cur_y  in  COORD_W  this router's Y coordinate; static.
- wr_en  in  1  upstream flit valid; write flit_in this cycle.
- flit_in  in  FLIT_SIZE  incoming flit.
- rd_en  in  1  allocator grant; pop the head flit.
- in_buf  out  FLIT_SIZE  head-of-FIFO flit, combinational from the storage array.
- empty  out  1  FIFO holds no flits.
- full  out  1  occupancy == BUF_DEPTH.
- op_port  out  OP_SIZE  requested output: 0=N, 1=E, 2=S, 3=W, 4=L.
- ON_OFF_signal  out  1  1 = upstream may send; registered.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Flit format:
  - [7:6] type: 10 head, 00 body, 01 tail, 11 head+tail (single-flit packet).
  - Head flits: [5:3] dest_x, [2:0] dest_y.
- Reset (rst=0, asynchronous):
  - Pointers and count cleared; empty=1, full=0.
  - ON_OFF_signal=1, protocol_err=0, state IDLE, latched route=4.
  - in_buf is don't-care while empty.
  - Reset mid-packet discards all stored flits.
- FIFO:
  - Circular buffer; rd_ptr and wr_ptr are $clog2(BUF_DEPTH) bits and wrap naturally.
  - count is $clog2(BUF_DEPTH)+1 bits.
  - Write when wr_en && (!full || rd_en).
  - wr_en while full without rd_en: flit dropped, pointers unchanged, protocol_err set.
  - Read when rd_en && !empty; rd_en while empty is ignored.
  - Simultaneous read and write: count unchanged, both pointers advance.
  - No bypass: a flit written into an empty FIFO appears on in_buf and clears empty on the next cycle.
- Route compute (combinational, from in_buf, XY order):
  - dest_x > cur_x -> E(1); dest_x < cur_x -> W(3).
  - Otherwise dest_y < cur_y -> N(0); dest_y > cur_y -> S(2).
  - Otherwise L(4).
- State machine:
  - IDLE:
    - op_port = route(in_buf) when in_buf is a head or head+tail flit.
    - If in_buf is body or tail: op_port=4 and protocol_err is set when that flit is read.
    - On a read of a head flit: latch route, go ACTIVE.
    - On a read of a head+tail flit: stay IDLE.
  - ACTIVE:
    - op_port = latched route, regardless of in_buf contents.
    - On a read of a tail flit: go IDLE.
    - A head flit read in ACTIVE sets protocol_err; the state is unchanged.
- ON_OFF_signal, registered from next-state count:
  - Next count >= OFF_TH -> 0.
  - Next count <= ON_TH -> 1.
  - Otherwise hold.
  - The upstream router has 1 cycle of reaction latency; BUF_DEPTH - OFF_TH >= 1 absorbs one in-flight flit.
- protocol_err clears only on reset.

Test Plan:
- Reset: drive rst=0 mid-traffic -> empty=1, full=0, ON_OFF_signal=1, protocol_err=0, op_port=4, all stored flits gone after release.
- 3-flit packet at cur=(1,1):
  - Stimulus: head 8'b10_011_001, body 8'h15, tail 8'h55; rd_en asserted whenever !empty.
  - Response: op_port=1 (E) from head through tail; state returns to IDLE after the tail read; flits leave on in_buf in order.
- Y-routing and single-flit packet: head+tail 8'b11_001_000 at cur=(1,1) -> op_port=0 (N), state stays IDLE; 8'b11_001_001 -> op_port=4.
- Fill and hysteresis:
  - Write 4 flits with no reads -> ON_OFF_signal falls on the edge where count reaches 3; full=1 at count 4.
  - A 5th write is dropped and sets protocol_err.
  - Then read 3 flits -> ON_OFF_signal returns to 1 when count reaches 1.
- Full with simultaneous read and write: count stays 4, pointers wrap correctly, the popped flit equals the oldest, the new flit is accepted, protocol_err=0.
- Wormhole hold: during an ACTIVE packet routed E, a body flit whose bits would decode to W -> op_port stays 1.
